// File: rtl/matrix_vector_streamer.sv
// Captures a flattened matrix on start and streams it out one vector per accepted handshake.
// Optional column (transposed) streaming is enabled by MATRIX_VECTOR_STREAMER_TRANSPOSE_EN.
module matrix_vector_streamer #(
  parameter int unsigned ELEM_W  = 16,
  parameter int unsigned VEC_LEN = 16,
  parameter int unsigned NUM_VEC = 16,
  localparam int unsigned VEC_W  = ELEM_W * VEC_LEN,
  localparam int unsigned MAT_W  = VEC_W * NUM_VEC,
  localparam int unsigned IDX_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [MAT_W-1:0]  Matrix,
  input  logic                     vec_ready,
  output logic signed [VEC_W-1:0]  Matrix_sel,
  output logic                     vec_valid,
  output logic [IDX_W-1:0]         vec_idx,
  output logic                     busy,
`ifdef MATRIX_VECTOR_STREAMER_TRANSPOSE_EN
  input  logic                     transpose,
`endif
  output logic                     finish
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VEC - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q;
  logic [MAT_W-1:0]   mat_q;
  logic               tr_q;
  logic               tr_in;
  logic [VEC_W-1:0]   row_vec [NUM_VEC];
  logic [VEC_W-1:0]   first_vec;
  logic [VEC_W-1:0]   next_vec;
  logic [IDX_W-1:0]   next_idx;

  assign next_idx = vec_idx + 1'b1;

  for (genvar v = 0; v < NUM_VEC; v++) begin : g_row
    assign row_vec[v] = mat_q[MAT_W-1-v*VEC_W -: VEC_W];
  end

`ifdef MATRIX_VECTOR_STREAMER_TRANSPOSE_EN
  if (VEC_LEN != NUM_VEC) begin : g_bad_cfg
    $error("transpose mode needs VEC_LEN == NUM_VEC");
  end

  logic [VEC_W-1:0] col_vec [NUM_VEC];
  logic [VEC_W-1:0] col0_in;

  // Column k gathers element k of every stored row, row 0 in the MSBs.
  for (genvar v = 0; v < NUM_VEC; v++) begin : g_col
    for (genvar e = 0; e < VEC_LEN; e++) begin : g_elem
      assign col_vec[v][VEC_W-1-e*ELEM_W -: ELEM_W] = mat_q[MAT_W-1-e*VEC_W-v*ELEM_W -: ELEM_W];
    end
  end
  for (genvar e = 0; e < VEC_LEN; e++) begin : g_col0
    assign col0_in[VEC_W-1-e*ELEM_W -: ELEM_W] = Matrix[MAT_W-1-e*VEC_W -: ELEM_W];
  end

  assign tr_in = transpose;

  always_comb begin
    first_vec = tr_in ? col0_in : Matrix[MAT_W-1 -: VEC_W];
    next_vec  = tr_q ? col_vec[next_idx] : row_vec[next_idx];
  end
`else
  assign tr_in = 1'b0;

  always_comb begin
    first_vec = Matrix[MAT_W-1 -: VEC_W];
    next_vec  = row_vec[next_idx];
  end
`endif

  assign busy      = (state_q == StRun);
  assign vec_valid = (state_q == StRun);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      Matrix_sel <= '0;
      vec_idx    <= '0;
      finish     <= 1'b0;
    end else begin
      finish <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mat_q      <= Matrix;
            tr_q       <= tr_in;
            Matrix_sel <= first_vec;
            vec_idx    <= '0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (vec_ready) begin
            // Last vector: hold data and index, just drop valid and pulse finish.
            if (vec_idx == LastIdx) begin
              state_q <= StIdle;
              finish  <= 1'b1;
            end else begin
              Matrix_sel <= next_vec;
              vec_idx    <= next_idx;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_vector_streamer.sv
// Scoreboard bench for matrix_vector_streamer: expected vectors are queued at start and
// compared on every handshake.
module tb_matrix_vector_streamer;

`ifdef MATRIX_VECTOR_STREAMER_TRANSPOSE_EN
  localparam int EW = 8;
  localparam int VL = 4;
  localparam int NV = 4;
`else
  localparam int EW = 16;
  localparam int VL = 16;
  localparam int NV = 16;
`endif
  localparam int VW = EW * VL;
  localparam int MW = VW * NV;
  localparam int IW = (NV > 1) ? $clog2(NV) : 1;
  localparam int CAP_IDX = (NV > 6) ? 5 : 1;
  localparam int ABORT_IDX = (NV > 8) ? 7 : NV - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          vec_ready = 1'b0;
  logic [MW-1:0] Matrix = '0;
  logic [VW-1:0] Matrix_sel;
  logic          vec_valid;
  logic [IW-1:0] vec_idx;
  logic          busy;
  logic          finish;
`ifdef MATRIX_VECTOR_STREAMER_TRANSPOSE_EN
  logic          transpose = 1'b0;
`endif

  matrix_vector_streamer #(
    .ELEM_W (EW),
    .VEC_LEN(VL),
    .NUM_VEC(NV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Matrix    (Matrix),
    .vec_ready (vec_ready),
    .Matrix_sel(Matrix_sel),
    .vec_valid (vec_valid),
    .vec_idx   (vec_idx),
    .busy      (busy),
`ifdef MATRIX_VECTOR_STREAMER_TRANSPOSE_EN
    .transpose (transpose),
`endif
    .finish    (finish)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [VW-1:0] exp_q[$];
  int            idx_q[$];

  function automatic logic [EW-1:0] elem(int base, int v, int e);
    return EW'(base + v * 16 + e);
  endfunction

  function automatic logic [MW-1:0] make_mat(int base);
    logic [MW-1:0] m = '0;
    for (int v = 0; v < NV; v++)
      for (int e = 0; e < VL; e++)
        m[MW-1-v*VW-e*EW -: EW] = elem(base, v, e);
    return m;
  endfunction

  task automatic push_matrix(int base, bit tr);
    logic [VW-1:0] x;
    for (int k = 0; k < NV; k++) begin
      for (int e = 0; e < VL; e++)
        x[VW-1-e*EW -: EW] = tr ? elem(base, e, k) : elem(base, k, e);
      exp_q.push_back(x);
      idx_q.push_back(k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; Matrix = make_mat(5);
    tick(); tick();
    total++; if (Matrix_sel !== '0) begin bad++; $display("FAIL reset_sel got=%h want=0", Matrix_sel); end
    total++; if (vec_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", vec_idx); end
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vec_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b want=0", finish); end
    rst = 1'b1; start = 1'b0;
    tick();
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b want=0", vec_valid); end
  endtask

  task automatic test_full_stream();
    Matrix = make_mat(0); push_matrix(0, 1'b0);
    start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= NV + 1; c++) begin
      if (c <= NV) begin
        total++; if (vec_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL full_valid cyc=%0d got=%b want=1", c, vec_valid); end
        total++; if (finish !== 1'b0) begin bad++; $display("FAIL full_early_finish cyc=%0d got=%b want=0", c, finish); end
        if (vec_valid && exp_q.size() > 0) begin
          total++; if (Matrix_sel !== exp_q[0]) begin bad++; $display("FAIL full_data cyc=%0d got=%h want=%h", c, Matrix_sel, exp_q[0]); end
          total++; if (vec_idx !== IW'(idx_q[0])) begin bad++; $display("FAIL full_idx cyc=%0d got=%0d want=%0d", c, vec_idx, idx_q[0]); end
          void'(exp_q.pop_front()); void'(idx_q.pop_front());
        end
      end else begin
        total++; if (finish !== 1'b1) begin bad++; $display("FAIL full_finish cyc=%0d got=%b want=1", c, finish); end
        total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL full_idle cyc=%0d got=%b want=0", c, vec_valid); end
        total++; if (Matrix_sel !== exp_last(0) || vec_idx !== IW'(NV - 1)) begin
          bad++; $display("FAIL full_hold got=%h/%0d want=%h/%0d", Matrix_sel, vec_idx, exp_last(0), NV - 1);
        end
      end
      tick();
    end
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL full_finish_pulse got=%b want=0", finish); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_left got=%0d want=0", exp_q.size()); end
    exp_q.delete(); idx_q.delete();
    vec_ready = 1'b0;
  endtask

  function automatic logic [VW-1:0] exp_last(int base);
    logic [VW-1:0] x;
    for (int e = 0; e < VL; e++) x[VW-1-e*EW -: EW] = elem(base, NV - 1, e);
    return x;
  endfunction

  task automatic test_backpressure();
    logic [VW-1:0] hsel;
    logic [IW-1:0] hidx;
    bit has_hold = 0;
    bit done = 0;
    int n = 0;
    Matrix = make_mat(32); push_matrix(32, 1'b0);
    start = 1'b1; vec_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8 * NV + 8 && !done; i++) begin
      vec_ready = (i % 4 == 0) || (i % 4 == 3);
      if (has_hold) begin
        total++;
        if (Matrix_sel !== hsel || vec_idx !== hidx || vec_valid !== 1'b1) begin
          bad++; $display("FAIL bp_stable got=%h/%0d/%b want=%h/%0d/1", Matrix_sel, vec_idx, vec_valid, hsel, hidx);
        end
      end
      if (finish) begin
        done = 1;
      end else if (vec_valid && vec_ready) begin
        total++;
        if (exp_q.size() == 0 || Matrix_sel !== exp_q[0] || vec_idx !== IW'(idx_q[0])) begin
          bad++; $display("FAIL bp_data n=%0d got=%h/%0d", n, Matrix_sel, vec_idx);
        end
        if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(idx_q.pop_front()); end
        n++; has_hold = 0;
      end else if (vec_valid) begin
        has_hold = 1; hsel = Matrix_sel; hidx = vec_idx;
      end
      tick();
    end
    total++; if (!done || n != NV) begin bad++; $display("FAIL bp_count got=%0d done=%0d want=%0d", n, done, NV); end
    exp_q.delete(); idx_q.delete();
    vec_ready = 1'b0;
  endtask

  task automatic test_capture();
    bit done = 0;
    int n = 0;
    Matrix = make_mat(64); push_matrix(64, 1'b0);
    start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 * NV && !done; i++) begin
      start = 1'b0;
      if (finish) begin
        done = 1;
      end else begin
        if (vec_valid && vec_idx == IW'(CAP_IDX)) begin
          Matrix = make_mat(16'h700); start = 1'b1;
        end
        if (vec_valid && vec_ready) begin
          total++;
          if (exp_q.size() == 0 || Matrix_sel !== exp_q[0] || vec_idx !== IW'(idx_q[0])) begin
            bad++; $display("FAIL cap_data n=%0d got=%h/%0d", n, Matrix_sel, vec_idx);
          end
          if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(idx_q.pop_front()); end
          n++;
        end
      end
      tick();
    end
    total++; if (!done || n != NV) begin bad++; $display("FAIL cap_count got=%0d want=%0d", n, NV); end
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL cap_restart got=%b want=0", vec_valid); end
    exp_q.delete(); idx_q.delete();
    vec_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int phase = 0;
    bit check_next = 0;
    int n = 0;
    Matrix = make_mat(0); push_matrix(0, 1'b0);
    start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 * NV && phase < 2; i++) begin
      start = 1'b0;
      if (check_next) begin
        total++; if (vec_valid !== 1'b1 || vec_idx !== '0) begin bad++; $display("FAIL b2b_restart got=%b/%0d want=1/0", vec_valid, vec_idx); end
        check_next = 0;
      end
      if (finish) begin
        if (phase == 0) begin
          Matrix = make_mat(16'h200); push_matrix(16'h200, 1'b0);
          start = 1'b1; check_next = 1;
        end
        phase++;
      end else if (vec_valid && vec_ready) begin
        total++;
        if (exp_q.size() == 0 || Matrix_sel !== exp_q[0] || vec_idx !== IW'(idx_q[0])) begin
          bad++; $display("FAIL b2b_data n=%0d got=%h/%0d", n, Matrix_sel, vec_idx);
        end
        if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(idx_q.pop_front()); end
        n++;
      end
      tick();
    end
    total++; if (phase != 2 || n != 2 * NV) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", n, 2 * NV); end
    exp_q.delete(); idx_q.delete();
    vec_ready = 1'b0;
  endtask

  task automatic test_abort();
    bit hit = 0;
    Matrix = make_mat(16'h300); push_matrix(16'h300, 1'b0);
    start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2 * NV && !hit; i++) begin
      if (vec_valid && vec_idx == IW'(ABORT_IDX)) begin
        hit = 1; rst = 1'b0;
      end else if (vec_valid && vec_ready) begin
        total++;
        if (exp_q.size() == 0 || Matrix_sel !== exp_q[0]) begin bad++; $display("FAIL abort_data got=%h", Matrix_sel); end
        if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(idx_q.pop_front()); end
      end
      tick();
    end
    rst = 1'b1;
    total++; if (!hit) begin bad++; $display("FAIL abort_reach got=0 want=1"); end
    total++; if (vec_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", vec_valid); end
    total++; if (Matrix_sel !== '0 || vec_idx !== '0) begin bad++; $display("FAIL abort_clear got=%h/%0d want=0/0", Matrix_sel, vec_idx); end
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL abort_finish got=%b want=0", finish); end
    tick();
    total++; if (finish !== 1'b0 || vec_valid !== 1'b0) begin bad++; $display("FAIL abort_after got=%b/%b want=0/0", finish, vec_valid); end
    exp_q.delete(); idx_q.delete();
    vec_ready = 1'b0;
  endtask

`ifdef MATRIX_VECTOR_STREAMER_TRANSPOSE_EN
  task automatic test_transpose();
    transpose = 1'b1;
    Matrix = make_mat(16'h10); push_matrix(16'h10, 1'b1);
    start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0; transpose = 1'b0;
    for (int c = 1; c <= NV; c++) begin
      total++;
      if (vec_valid !== 1'b1 || exp_q.size() == 0 || Matrix_sel !== exp_q[0] || vec_idx !== IW'(idx_q[0])) begin
        bad++; $display("FAIL tr_col cyc=%0d got=%h/%0d", c, Matrix_sel, vec_idx);
      end
      if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(idx_q.pop_front()); end
      tick();
    end
    total++; if (finish !== 1'b1) begin bad++; $display("FAIL tr_finish got=%b want=1", finish); end
    exp_q.delete(); idx_q.delete();
    vec_ready = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_stream();
    test_backpressure();
    test_capture();
    test_back_to_back();
    test_abort();
`ifdef MATRIX_VECTOR_STREAMER_TRANSPOSE_EN
    test_transpose();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
